wordle_scorer: RTL
==================

# wordle_scorer

Per-guess scoring engine downstream of the Wordle game state machine. When a completed five-letter guess is presented, the block compares it with the word of the day and produces a Wordle colour per letter: green, yellow or gray, with correct duplicate-letter accounting. It runs as a fixed-latency sequential scan so the display stage can tile-colour each row. It also reports an all-green flag for the win indication.

## Interface

- LETTER_W, 8: bits per letter (ASCII).
- Clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, one synchronous active-high reset.
- Start  in  1  single-cycle request; sampled only in IDLE.
- guess  in  5*LETTER_W  guess letters; position 0 in the MS byte (first_letter), position 4 in the LS byte.
- answer  in  5*LETTER_W  word of the day, same packing.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle pulse; colors valid from this cycle on.
- colors  out  10  2 bits per position; [9:8] is position 0. Encoding: 00 gray, 01 yellow, 10 green, 11 unused.
- all_green  out  1  colors == 10'h2AA, registered with Done.

## Operation

- States: IDLE, GREEN, YELLOW, DONE.
- IDLE: Start=1 latches guess/answer into internal registers, clears colors, used[4:0], i, j. Next state is GREEN. Start=0 holds colors and all_green.
- GREEN: i steps 0..4, one cycle each. If g[i]==a[i]: colors[i]=green, used[i]=1. After i=4: i=0, j=0, go YELLOW.
- YELLOW: nested scan, i outer 0..4, j inner 0..4, one (i,j) pair per cycle, always 25 cycles. Mark yellow when colors[i]==gray && !used[j] && g[i]==a[j]. Marking sets colors[i]=yellow and used[j]=1. Later j for the same i cannot re-mark because the colour is no longer gray. After (4,4) go DONE.
- DONE: Done=1 and all_green computed for one cycle, then IDLE.
- Start outside IDLE is ignored; there is no queueing.
- Input changes after acceptance have no effect, because the operands are latched.
- Letters are compared as raw LETTER_W-bit equality. Case folding is upstream's job; 8'h00 matches 8'h00.
- Duplicate rule: the count of yellow+green marks for a letter never exceeds that letter's count in answer. Greens take priority; yellows are assigned left to right.

## Timing

- Start accepted at edge k gives GREEN in cycles k+1..k+5, YELLOW in k+6..k+30, and DONE (Done=1) in cycle k+31.
- Latency is fixed at 31 cycles, independent of data.
- Busy is high in cycles k+1..k+31 and low in IDLE.
- The earliest next Start is accepted at edge k+32.
- Reset values: state=IDLE, Busy=0, Done=0, colors=10'h000, all_green=0, used=0, i=j=0.
- reset mid-operation aborts on the next edge with the same values; no Done is issued.
- reset and Start in the same cycle: reset wins.
- colors and all_green hold after Done until the next accepted Start, which clears them on the acceptance edge.

## Structure

- Shared package wordle_pkg:
  - WORD_LEN=5, LETTER_W default.
  - Colour constants COL_GRAY/COL_YELLOW/COL_GREEN.
  - Scorer state encoding.
  - ALL_GREEN constant 10'h2AA.
- Byte selection of position p is a function in wordle_pkg; no sub-module is needed.
- Single module, single always block for sequential logic. Counters i and j are 3 bits, with wrap handled explicitly at 4.

## Test plan

- answer "ROBOT", guess "ROBOT", Start pulse -> Done exactly 31 cycles later, colors=10'h2AA, all_green=1, Busy high for 31 cycles.
- answer "ROBOT", guess "BOOTH" -> colors=10'h194 (Y,G,Y,Y,gray), all_green=0.
- Duplicates vs greens: answer "ABBOT", guess "BBBBB" -> 10'h0A0; answer "CACAO", guess "AAAAA" -> 10'h088.
- Left-to-right yellows: answer "LAPSE", guess "EEEEL" -> 10'h101 (only the first E is yellow, L is yellow).
- Start re-pulsed while Busy, with guess changed mid-scan -> ignored; result matches the originally latched operands with unchanged latency.
- reset asserted at cycle k+10 -> next cycle IDLE, colors=0, Busy=0, no Done pulse. A fresh Start then scores normally.

Source files
------------

// File: rtl/wordle_pkg.sv
// wordle_pkg: shared constants, state encoding and letter selection for the Wordle scorer
package wordle_pkg;
  localparam int WORD_LEN = 5;
  localparam int LETTER_W = 8;
  localparam logic [1:0] COL_GRAY = 2'b00;
  localparam logic [1:0] COL_YELLOW = 2'b01;
  localparam logic [1:0] COL_GREEN = 2'b10;
  localparam logic [2*WORD_LEN-1:0] ALL_GREEN = 10'h2AA;
  typedef enum logic [1:0] {S_IDLE, S_GREEN, S_YELLOW, S_DONE} scorer_state_t;
  function automatic logic [LETTER_W-1:0] letter_at(input logic [WORD_LEN*LETTER_W-1:0] w, input logic [2:0] p);
    return w[(WORD_LEN-1-int'(p))*LETTER_W +: LETTER_W];
  endfunction
endpackage

// File: rtl/wordle_scorer.sv
// wordle_scorer: fixed-latency green/yellow/gray scoring of a latched guess against the answer
module wordle_scorer
  import wordle_pkg::*;
(
  input  logic                         Clk,
  input  logic                         reset,
  input  logic                         Start,
  input  logic [WORD_LEN*LETTER_W-1:0] guess,
  input  logic [WORD_LEN*LETTER_W-1:0] answer,
  output logic                         Busy,
  output logic                         Done,
  output logic [2*WORD_LEN-1:0]        colors,
  output logic                         all_green
);
  scorer_state_t r_state, w_state_nxt;
  logic [WORD_LEN*LETTER_W-1:0] r_g, r_a;
  logic [2*WORD_LEN-1:0] r_colors, w_col_nxt;
  logic [WORD_LEN-1:0] r_used, w_used_nxt;
  logic [2:0] r_i, r_j, w_i_nxt, w_j_nxt;
  logic r_all_green;
  logic [3:0] w_off_i;
  logic w_green_hit, w_yellow_hit;
  assign w_off_i = 4'd8 - {r_i, 1'b0};
  assign w_green_hit = letter_at(r_g, r_i) == letter_at(r_a, r_i);
  assign w_yellow_hit = r_colors[w_off_i +: 2] == COL_GRAY && !r_used[r_j] && letter_at(r_g, r_i) == letter_at(r_a, r_j);
  assign Busy = r_state != S_IDLE;
  assign Done = r_state == S_DONE;
  assign colors = r_colors;
  assign all_green = r_all_green;
  // next state, colour/used updates and scan counter stepping
  always_comb begin
    w_state_nxt = r_state;
    w_col_nxt = r_colors;
    w_used_nxt = r_used;
    w_i_nxt = r_i;
    w_j_nxt = r_j;
    case (r_state)
      S_IDLE: if (Start) begin
        w_state_nxt = S_GREEN;
        w_col_nxt = '0;
        w_used_nxt = '0;
        w_i_nxt = '0;
        w_j_nxt = '0;
      end
      S_GREEN: begin
        if (w_green_hit) begin
          w_col_nxt[w_off_i +: 2] = COL_GREEN;
          w_used_nxt[r_i] = 1'b1;
        end
        w_i_nxt = r_i == 3'd4 ? 3'd0 : r_i + 3'd1;
        w_j_nxt = '0;
        w_state_nxt = r_i == 3'd4 ? S_YELLOW : S_GREEN;
      end
      S_YELLOW: begin
        if (w_yellow_hit) begin
          w_col_nxt[w_off_i +: 2] = COL_YELLOW;
          w_used_nxt[r_j] = 1'b1;
        end
        w_j_nxt = r_j == 3'd4 ? 3'd0 : r_j + 3'd1;
        w_i_nxt = r_j != 3'd4 ? r_i : r_i == 3'd4 ? 3'd0 : r_i + 3'd1;
        w_state_nxt = r_j == 3'd4 && r_i == 3'd4 ? S_DONE : S_YELLOW;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
  // state, operand latch and result registers; all_green is captured as the scan completes
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_g <= '0;
      r_a <= '0;
      r_colors <= '0;
      r_used <= '0;
      r_i <= '0;
      r_j <= '0;
      r_all_green <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_colors <= w_col_nxt;
      r_used <= w_used_nxt;
      r_i <= w_i_nxt;
      r_j <= w_j_nxt;
      if (r_state == S_IDLE && Start) begin
        r_g <= guess;
        r_a <= answer;
        r_all_green <= 1'b0;
      end
      if (r_state == S_YELLOW && w_state_nxt == S_DONE) r_all_green <= w_col_nxt == ALL_GREEN;
    end
  end
endmodule
